vga_rect_layer_module: RTL and testbench
========================================

VGA_RECT_LAYER_MODULE -- requirements
Module: vga_rect_layer_module

Interface
REQ-001 SHALL have parameter N_RECT, default 4, number of rectangle layers (1..8).
REQ-002 SHALL have parameter XW, default 10, X coordinate width; parameter YW, default 10, Y coordinate width.
REQ-003 SHALL have parameters RW/GW/BW, defaults 3/3/2, red/green/blue channel widths; CW = RW+GW+BW.
REQ-004 SHALL have parameter BG_COLOR, default 0, CW-bit background colour {R,G,B}.
REQ-005 SHALL have parameter BLINK_FRAMES, default 30, frames per blink phase (used only under VGA_RECT_BLINK_EN).
REQ-006 VGA_CLK  input  1  pixel clock, all logic on rising edge.
REQ-007 RST_N  input  1  asynchronous, active-low reset.
REQ-008 X  input  XW  current pixel column; Y  input  YW  current pixel row.
REQ-009 valid  input  1  high when X/Y lie in the visible area.
REQ-010 cfg_we  input  1  shadow-register write strobe, one write per high cycle.
REQ-011 cfg_idx  input  3  target rectangle index; writes with cfg_idx >= N_RECT SHALL be ignored.
REQ-012 cfg_x0/cfg_x1  input  XW  inclusive column bounds; cfg_y0/cfg_y1  input  YW  inclusive row bounds.
REQ-013 cfg_color  input  CW  rectangle colour; cfg_en  input  1  rectangle enable; cfg_blink  input  1  blink select.
REQ-014 cfg_pending  output  1  high while shadow contents differ from active set (uncommitted writes).
REQ-015 VGA_R  output  RW; VGA_G  output  GW; VGA_B  output  BW  registered pixel colour.

Function
REQ-016 SHALL hold two register sets per rectangle: shadow (written by cfg port) and active (used for drawing).
REQ-017 A cycle with cfg_we=1 and valid index SHALL load all fields of shadow[cfg_idx] at the clock edge and set cfg_pending.
REQ-018 Commit SHALL occur on every cycle with X==0 and Y==0; commit copies all shadow sets to active and clears cfg_pending.
REQ-019 Write and commit in the same cycle SHALL commit the newly written values (write-through) and leave cfg_pending=0.
REQ-020 Rectangle i SHALL hit when active en=1, x0<=X<=x1 and y0<=Y<=y1 (unsigned); x0>x1 or y0>y1 SHALL never hit.
REQ-021 Stage 1 SHALL register the N_RECT hit vector plus valid; stage 2 SHALL register colour outputs; latency X/Y/valid to VGA_* is exactly 2 cycles.
REQ-022 When several rectangles hit, lowest index SHALL win; no hit yields BG_COLOR.
REQ-023 When delayed valid is 0, VGA_R/G/B SHALL be all zeros regardless of hits.
REQ-024 Colour SHALL split as R = color[CW-1:GW+BW], G = color[GW+BW-1:BW], B = color[BW-1:0].
REQ-025 Config changes SHALL never alter drawing mid-frame; only commit updates the active set.

Reset
REQ-026 RST_N low SHALL asynchronously clear VGA_R/G/B to 0, cfg_pending to 0, pipeline registers to 0.
REQ-027 Reset SHALL clear all shadow and active sets (en=0, bounds 0, colour 0, blink 0); first post-reset frame shows BG_COLOR.
REQ-028 Reset mid-frame SHALL discard uncommitted writes; release SHALL be honoured on the next rising edge.

Configuration
REQ-029 Macro VGA_RECT_BLINK_EN SHALL compile in the blink feature.
REQ-030 With VGA_RECT_BLINK_EN: a frame counter SHALL increment at each commit, wrap at BLINK_FRAMES-1, and toggle a phase bit on wrap; phase resets to 0.
REQ-031 With VGA_RECT_BLINK_EN: rectangle with active blink=1 SHALL not hit while phase=1 (lower-priority layers or BG show through).
REQ-032 Without VGA_RECT_BLINK_EN: cfg_blink SHALL be ignored, no counter exists, behaviour equals blink=0 everywhere.

Verification
REQ-033 Reset, write rect0 (10..20,10..20, colour 8'hE0, en=1), commit at (0,0) -> pixel (15,15) gives R=7,G=0,B=0 two cycles later; (21,15) gives BG.
REQ-034 Rect0 and rect1 overlap at (15,15), colours 8'hE0 and 8'h1C -> output R=7,G=0,B=0 (rect0 wins); disable rect0 -> G=7 after next commit.
REQ-035 Write mid-frame at (100,50) -> cfg_pending=1, drawing unchanged until next (0,0), then new colour appears and cfg_pending=0.
REQ-036 cfg_we at same cycle as X=0,Y=0 -> value live in that frame, cfg_pending stays 0; cfg_idx=7 with N_RECT=4 -> no change.
REQ-037 valid=0 at hit pixel -> VGA_R/G/B=0; x0=30,x1=20 -> never hits.
REQ-038 With VGA_RECT_BLINK_EN, BLINK_FRAMES=2, blink=1 -> rectangle visible frames 0-1, hidden 2-3, visible 4-5; without macro always visible.

Source files
------------

// File: rtl/vga_rect_layer_module.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : vga_rect_layer_module
// Purpose  : Prioritised solid-rectangle overlay with double-buffered config
//            committed at pixel (0,0). Optional blink: define VGA_RECT_BLINK_EN.
// Revision : 1.0 - initial release
// =============================================================================
module vga_rect_layer_module #(
   parameter int                   N_RECT       = 4,
   parameter int                   XW           = 10,
   parameter int                   YW           = 10,
   parameter int                   RW           = 3,
   parameter int                   GW           = 3,
   parameter int                   BW           = 2,
   parameter logic [RW+GW+BW-1:0]  BG_COLOR     = '0,
   parameter int                   BLINK_FRAMES = 30
) (
   input  logic                   VGA_CLK,
   input  logic                   RST_N,
   input  logic [XW-1:0]          X,
   input  logic [YW-1:0]          Y,
   input  logic                   valid,
   input  logic                   cfg_we,
   input  logic [2:0]             cfg_idx,
   input  logic [XW-1:0]          cfg_x0,
   input  logic [XW-1:0]          cfg_x1,
   input  logic [YW-1:0]          cfg_y0,
   input  logic [YW-1:0]          cfg_y1,
   input  logic [RW+GW+BW-1:0]    cfg_color,
   input  logic                   cfg_en,
   input  logic                   cfg_blink,
   output logic                   cfg_pending,
   output logic [RW-1:0]          VGA_R,
   output logic [GW-1:0]          VGA_G,
   output logic [BW-1:0]          VGA_B
);

   localparam int CW = RW + GW + BW;

   typedef struct packed {
      logic          en;
`ifdef VGA_RECT_BLINK_EN
      logic          blink;
`endif
      logic [XW-1:0] x0;
      logic [XW-1:0] x1;
      logic [YW-1:0] y0;
      logic [YW-1:0] y1;
      logic [CW-1:0] color;
   } rect_t;

   rect_t             r_shadow     [N_RECT];
   rect_t             r_active     [N_RECT];
   rect_t             w_shadow_nxt [N_RECT];
   rect_t             w_active_nxt [N_RECT];
   rect_t             w_cfg;
   logic              w_commit;
   logic              w_write;
   logic              w_phase_nxt;
   logic [N_RECT-1:0] w_hit;
   logic [N_RECT-1:0] r_hit;
   logic [CW-1:0]     w_win_color;
   logic [CW-1:0]     r_win_color;
   logic              r_valid;
   logic [CW-1:0]     w_pix;

   assign w_commit = (X == '0) && (Y == '0);
   assign w_write  = cfg_we && (int'(cfg_idx) < N_RECT);

   always_comb begin
      w_cfg       = '0;
      w_cfg.en    = cfg_en;
      w_cfg.x0    = cfg_x0;
      w_cfg.x1    = cfg_x1;
      w_cfg.y0    = cfg_y0;
      w_cfg.y1    = cfg_y1;
      w_cfg.color = cfg_color;
`ifdef VGA_RECT_BLINK_EN
      w_cfg.blink = cfg_blink;
`endif
   end

`ifdef VGA_RECT_BLINK_EN
   localparam int c_cnt_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [c_cnt_w-1:0] r_frame_cnt;
   logic [c_cnt_w-1:0] w_frame_cnt_nxt;
   logic               r_phase;

   always_comb begin
      w_frame_cnt_nxt = r_frame_cnt;
      w_phase_nxt     = r_phase;
      if (w_commit) begin
         if (r_frame_cnt == c_cnt_w'(BLINK_FRAMES - 1)) begin
            w_frame_cnt_nxt = '0;
            w_phase_nxt     = ~r_phase;
         end else begin
            w_frame_cnt_nxt = r_frame_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge VGA_CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_frame_cnt <= '0;
         r_phase     <= 1'b0;
      end else begin
         r_frame_cnt <= w_frame_cnt_nxt;
         r_phase     <= w_phase_nxt;
      end
   end
`else
   localparam int c_unused_blink_frames = BLINK_FRAMES;
   logic w_unused_blink;
   assign w_unused_blink = cfg_blink;
   assign w_phase_nxt    = 1'b0;
`endif

   // A write landing on the commit cycle is forwarded straight into the active set.
   always_comb begin
      for (int i = 0; i < N_RECT; i++) begin
         w_shadow_nxt[i] = r_shadow[i];
         if (w_write && (cfg_idx == 3'(i)))
            w_shadow_nxt[i] = w_cfg;
         w_active_nxt[i] = w_commit ? w_shadow_nxt[i] : r_active[i];
      end
   end

   // Hits use the post-commit set so pixel (0,0) already belongs to the new frame.
   always_comb begin
      w_hit       = '0;
      w_win_color = '0;
      for (int i = N_RECT - 1; i >= 0; i--) begin
         w_hit[i] = w_active_nxt[i].en &&
                    (X >= w_active_nxt[i].x0) && (X <= w_active_nxt[i].x1) &&
                    (Y >= w_active_nxt[i].y0) && (Y <= w_active_nxt[i].y1);
`ifdef VGA_RECT_BLINK_EN
         if (w_active_nxt[i].blink && w_phase_nxt)
            w_hit[i] = 1'b0;
`endif
         if (w_hit[i])
            w_win_color = w_active_nxt[i].color;
      end
   end

   always_comb begin
      if (!r_valid)
         w_pix = '0;
      else if (|r_hit)
         w_pix = r_win_color;
      else
         w_pix = BG_COLOR;
   end

   always_ff @(posedge VGA_CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < N_RECT; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
         cfg_pending <= 1'b0;
         r_hit       <= '0;
         r_win_color <= '0;
         r_valid     <= 1'b0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
      end else begin
         for (int i = 0; i < N_RECT; i++) begin
            r_shadow[i] <= w_shadow_nxt[i];
            r_active[i] <= w_active_nxt[i];
         end
         if (w_commit)
            cfg_pending <= 1'b0;
         else if (w_write)
            cfg_pending <= 1'b1;
         r_hit       <= w_hit;
         r_win_color <= w_win_color;
         r_valid     <= valid;
         VGA_R       <= w_pix[CW-1:GW+BW];
         VGA_G       <= w_pix[GW+BW-1:BW];
         VGA_B       <= w_pix[BW-1:0];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_layer_module.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for vga_rect_layer_module: directed scenarios plus random scan/config
// traffic compared pixel by pixel with a frame-level reference model.
module tb_vga_rect_layer_module;

   localparam int         N  = 4;
   localparam int         BF = 2;
   localparam logic [7:0] BG = 8'h25;

   typedef struct packed {
      logic       en;
      logic       blink;
      logic [9:0] x0;
      logic [9:0] x1;
      logic [9:0] y0;
      logic [9:0] y1;
      logic [7:0] color;
   } rect_t;

   logic       VGA_CLK = 1'b0;
   logic       RST_N   = 1'b1;
   logic [9:0] X = '0, Y = '0;
   logic       valid = 1'b0, cfg_we = 1'b0, cfg_en = 1'b0, cfg_blink = 1'b0;
   logic [2:0] cfg_idx = '0;
   logic [9:0] cfg_x0 = '0, cfg_x1 = '0, cfg_y0 = '0, cfg_y1 = '0;
   logic [7:0] cfg_color = '0;
   logic       cfg_pending;
   logic [2:0] VGA_R, VGA_G;
   logic [1:0] VGA_B;

   always #5 VGA_CLK = ~VGA_CLK;

   vga_rect_layer_module #(
      .N_RECT(N), .XW(10), .YW(10), .RW(3), .GW(3), .BW(2),
      .BG_COLOR(BG), .BLINK_FRAMES(BF)
   ) dut (
      .VGA_CLK(VGA_CLK), .RST_N(RST_N), .X(X), .Y(Y), .valid(valid),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x0(cfg_x0), .cfg_x1(cfg_x1),
      .cfg_y0(cfg_y0), .cfg_y1(cfg_y1), .cfg_color(cfg_color), .cfg_en(cfg_en),
      .cfg_blink(cfg_blink), .cfg_pending(cfg_pending),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
   );

   // Reference model: shadow/active tables, commit count, 2-deep expectation delay
   rect_t      m_sh  [8];
   rect_t      m_act [8];
   bit         m_pend;
   int         m_commits;
   logic [7:0] e1, e2;
   int         e1x, e1y, e2x, e2y;
   int         vectors = 0;
   int         miscompares = 0;
   rect_t      none = '0;

   function automatic rect_t mk(input int x0, input int x1, input int y0, input int y1,
                                input logic [7:0] c, input bit en, input bit bl);
      rect_t r;
      r.x0 = x0[9:0]; r.x1 = x1[9:0]; r.y0 = y0[9:0]; r.y1 = y1[9:0];
      r.color = c; r.en = en; r.blink = bl;
      return r;
   endfunction

   function automatic rect_t rand_rect();
      return mk($urandom_range(0, 45), $urandom_range(0, 45), $urandom_range(0, 35),
                $urandom_range(0, 35), 8'($urandom), ($urandom_range(0, 3) != 0),
                1'($urandom));
   endfunction

   function automatic logic [7:0] model_pix(input int x, input int y, input bit v);
      bit hidden;
`ifdef VGA_RECT_BLINK_EN
      hidden = ((m_commits / BF) % 2) == 1;
`else
      hidden = 1'b0;
`endif
      if (!v) return 8'h00;
      for (int i = 0; i < N; i++)
         if (m_act[i].en && !(m_act[i].blink && hidden) &&
             x >= int'(m_act[i].x0) && x <= int'(m_act[i].x1) &&
             y >= int'(m_act[i].y0) && y <= int'(m_act[i].y1))
            return m_act[i].color;
      return BG;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) begin
         m_sh[i] = '0;
         m_act[i] = '0;
      end
      m_pend = 1'b0; m_commits = 0;
      e1 = '0; e2 = '0; e1x = -1; e1y = -1; e2x = -1; e2y = -1;
   endfunction

   task automatic apply(input int x, input int y, input bit v, input bit we,
                        input int idx, input rect_t c);
      X = x[9:0]; Y = y[9:0]; valid = v; cfg_we = we; cfg_idx = idx[2:0];
      cfg_x0 = c.x0; cfg_x1 = c.x1; cfg_y0 = c.y0; cfg_y1 = c.y1;
      cfg_color = c.color; cfg_en = c.en; cfg_blink = c.blink;
      if (we && idx < N) m_sh[idx] = c;
      if (x == 0 && y == 0) begin
         for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
         m_pend = 1'b0;
         m_commits++;
      end else if (we && idx < N) begin
         m_pend = 1'b1;
      end
      e2 = e1; e2x = e1x; e2y = e1y;
      e1 = model_pix(x, y, v); e1x = x; e1y = y;
   endtask

   task automatic do_reset(output logic [7:0] col, output logic pend);
      @(negedge VGA_CLK);
      #1 RST_N = 1'b0;
      #1 col = {VGA_R, VGA_G, VGA_B};
      pend = cfg_pending;
      repeat (2) @(negedge VGA_CLK);
      model_reset();
      apply(1023, 1023, 1'b0, 1'b0, 0, none);
      RST_N = 1'b1;
   endtask

   // One raster frame; every pixel and the pending flag are checked against the model
   task automatic run_frame(input int w, input int h, input bit rnd,
                            input int wx, input int wy, input int widx, input rect_t wcfg,
                            input int px, input int py, input bit pinval,
                            output logic [7:0] pcol, output logic ppend);
      bit    v, we;
      int    idx;
      rect_t c;
      pcol = 'x; ppend = 'x;
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            @(negedge VGA_CLK);
            vectors++;
            if ({VGA_R, VGA_G, VGA_B} !== e2) begin
               miscompares++;
               $display("FAIL pixel(%0d,%0d): got %h expected %h", e2x, e2y,
                        {VGA_R, VGA_G, VGA_B}, e2);
            end
            vectors++;
            if (cfg_pending !== m_pend) begin
               miscompares++;
               $display("FAIL cfg_pending at (%0d,%0d): got %b expected %b", x, y,
                        cfg_pending, m_pend);
            end
            if (e2x == px && e2y == py) begin
               pcol = {VGA_R, VGA_G, VGA_B};
               ppend = cfg_pending;
            end
            v = 1'b1; we = 1'b0; idx = 0; c = none;
            if (rnd) begin
               v = ($urandom_range(0, 7) != 0);
               if ($urandom_range(0, 99) < 4) begin
                  we = 1'b1; idx = int'($urandom_range(0, 7)); c = rand_rect();
               end
            end
            if (x == wx && y == wy) begin
               we = 1'b1; idx = widx; c = wcfg;
            end
            if (x == px && y == py && pinval) v = 1'b0;
            apply(x, y, v, we, idx, c);
         end
      end
   endtask

   task automatic test_reset();
      logic [7:0] col;
      logic       pend;
      do_reset(col, pend);
      vectors++;
      if (col !== 8'h00) begin
         miscompares++; $display("FAIL reset_rgb: got %h expected 00", col);
      end
      vectors++;
      if (pend !== 1'b0) begin
         miscompares++; $display("FAIL reset_pending: got %b expected 0", pend);
      end
   endtask

   task automatic test_basic();
      logic [7:0] col;
      logic       pend;
      run_frame(40, 30, 0, 30, 25, 0, mk(10, 20, 10, 20, 8'hE0, 1, 0), 15, 15, 0, col, pend);
      vectors++;
      if (col !== BG) begin
         miscompares++; $display("FAIL basic_precommit: got %h expected %h", col, BG);
      end
      run_frame(40, 30, 0, -1, -1, 0, none, 15, 15, 0, col, pend);
      vectors++;
      if (col !== 8'hE0) begin
         miscompares++; $display("FAIL basic_hit: got %h expected e0", col);
      end
      run_frame(40, 30, 0, -1, -1, 0, none, 21, 15, 0, col, pend);
      vectors++;
      if (col !== BG) begin
         miscompares++; $display("FAIL basic_edge_x21: got %h expected %h", col, BG);
      end
      run_frame(40, 30, 0, -1, -1, 0, none, 20, 20, 0, col, pend);
      vectors++;
      if (col !== 8'hE0) begin
         miscompares++; $display("FAIL basic_corner_inclusive: got %h expected e0", col);
      end
   endtask

   task automatic test_priority();
      logic [7:0] col;
      logic       pend;
      run_frame(40, 30, 0, 30, 25, 1, mk(12, 25, 12, 25, 8'h1C, 1, 0), 15, 15, 0, col, pend);
      run_frame(40, 30, 0, 30, 25, 0, mk(10, 20, 10, 20, 8'hE0, 0, 0), 15, 15, 0, col, pend);
      vectors++;
      if (col !== 8'hE0) begin
         miscompares++; $display("FAIL priority_overlap: got %h expected e0", col);
      end
      run_frame(40, 30, 0, -1, -1, 0, none, 15, 15, 0, col, pend);
      vectors++;
      if (col !== 8'h1C) begin
         miscompares++; $display("FAIL priority_disable: got %h expected 1c", col);
      end
   endtask

   task automatic test_shadow();
      logic [7:0] col;
      logic       pend;
      run_frame(110, 60, 0, 100, 50, 2, mk(0, 109, 55, 59, 8'h1F, 1, 0), 50, 57, 0, col, pend);
      vectors++;
      if (col !== BG || pend !== 1'b1) begin
         miscompares++;
         $display("FAIL shadow_hold: got col=%h pend=%b expected col=%h pend=1", col, pend, BG);
      end
      run_frame(110, 60, 0, -1, -1, 0, none, 50, 57, 0, col, pend);
      vectors++;
      if (col !== 8'h1F || pend !== 1'b0) begin
         miscompares++;
         $display("FAIL shadow_commit: got col=%h pend=%b expected col=1f pend=0", col, pend);
      end
   endtask

   task automatic test_write_through();
      logic [7:0] col;
      logic       pend;
      run_frame(40, 30, 0, 0, 0, 3, mk(30, 35, 25, 28, 8'h92, 1, 0), 32, 26, 0, col, pend);
      vectors++;
      if (col !== 8'h92 || pend !== 1'b0) begin
         miscompares++;
         $display("FAIL write_through: got col=%h pend=%b expected col=92 pend=0", col, pend);
      end
      run_frame(40, 30, 0, 5, 5, 7, mk(0, 39, 0, 29, 8'hFF, 1, 0), 8, 8, 0, col, pend);
      vectors++;
      if (col !== BG || pend !== 1'b0) begin
         miscompares++;
         $display("FAIL ignored_idx_pending: got col=%h pend=%b expected col=%h pend=0",
                  col, pend, BG);
      end
      run_frame(40, 30, 0, -1, -1, 0, none, 2, 2, 0, col, pend);
      vectors++;
      if (col !== BG) begin
         miscompares++; $display("FAIL ignored_idx_draw: got %h expected %h", col, BG);
      end
   endtask

   task automatic test_valid_and_inverted();
      logic [7:0] col;
      logic       pend;
      run_frame(40, 30, 0, 30, 25, 0, mk(30, 20, 0, 29, 8'hFF, 1, 0), 15, 15, 1, col, pend);
      vectors++;
      if (col !== 8'h00) begin
         miscompares++; $display("FAIL valid_blank: got %h expected 00", col);
      end
      run_frame(40, 30, 0, -1, -1, 0, none, 25, 5, 0, col, pend);
      vectors++;
      if (col !== BG) begin
         miscompares++; $display("FAIL inverted_x: got %h expected %h", col, BG);
      end
   endtask

   task automatic test_random();
      logic [7:0] col;
      logic       pend;
      for (int f = 0; f < 4; f++)
         run_frame(40, 30, 1, -1, -1, 0, none, -5, -5, 0, col, pend);
   endtask

   task automatic test_reset_midframe();
      logic [7:0] col;
      logic       pend;
      run_frame(40, 30, 0, 39, 29, 0, mk(10, 20, 10, 20, 8'hE0, 1, 0), -5, -5, 0, col, pend);
      @(negedge VGA_CLK);
      vectors++;
      if (cfg_pending !== 1'b1) begin
         miscompares++; $display("FAIL midframe_pending: got %b expected 1", cfg_pending);
      end
      do_reset(col, pend);
      vectors++;
      if (col !== 8'h00 || pend !== 1'b0) begin
         miscompares++;
         $display("FAIL async_clear: got col=%h pend=%b expected col=00 pend=0", col, pend);
      end
      run_frame(40, 30, 0, -1, -1, 0, none, 15, 15, 0, col, pend);
      vectors++;
      if (col !== BG) begin
         miscompares++; $display("FAIL reset_discard: got %h expected %h", col, BG);
      end
   endtask

   task automatic test_blink();
      logic [7:0] col, exp;
      logic       pend;
      do_reset(col, pend);
      run_frame(40, 30, 0, 30, 25, 1, mk(12, 25, 12, 25, 8'h1C, 1, 1), -5, -5, 0, col, pend);
      for (int f = 1; f <= 6; f++) begin
         run_frame(40, 30, 0, -1, -1, 0, none, 15, 15, 0, col, pend);
`ifdef VGA_RECT_BLINK_EN
         exp = ((((f + 1) / BF) % 2) == 0) ? 8'h1C : BG;
`else
         exp = 8'h1C;
`endif
         vectors++;
         if (col !== exp) begin
            miscompares++; $display("FAIL blink_frame%0d: got %h expected %h", f, col, exp);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_priority();
      test_shadow();
      test_write_through();
      test_valid_and_inverted();
      test_random();
      test_reset_midframe();
      test_blink();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
